sprite_animator: RTL and testbench
==================================

SPRITE_ANIMATOR -- requirements
Module: sprite_animator

Interface
REQ-001 Parameter SPRITE_X, default 292: left column of the sprite box.
REQ-002 Parameter SPRITE_Y, default 350: top row of the sprite box.
REQ-003 Parameter SPRITE_W, default 17: sprite width in pixels.
REQ-004 Parameter SPRITE_H, default 24: sprite height in pixels.
REQ-005 Parameter STEP_DIV, default 8: number of VS rising edges per walk-phase advance (minimum 1).
REQ-006 Parameter TRANSPARENT_IDX, default 0: palette index rendered as background.
REQ-007 Port Clk, input, 1 bit: the single clock. The reset is asynchronous and active-high.
REQ-008 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 Port VS, input, 1 bit: vertical sync, synchronous to Clk.
REQ-010 Port Character_Moving, input, 1 bit: walk request.
REQ-011 Port Direction, input, 2 bits: 0 = up, 1 = right, 2 = down, 3 = left.
REQ-012 Ports DrawX and DrawY, input, 10 bits each: current pixel coordinates.
REQ-013 Port Rom_Addr, output, ROM_AW bits: sprite ROM address, registered.
REQ-014 Port Rom_Data, input, PAL_W bits: palette index; valid exactly 1 cycle after Rom_Addr.
REQ-015 Port Anim_Frame, output, 4 bits: logical frame, computed as Direction_state*4 + phase.
REQ-016 Ports Red, Green and Blue, output, 8 bits each: registered pixel colour.

Function
REQ-017 The VS rising edge SHALL be detected with a registered previous-VS sample; this produces a 1-cycle vs_tick.
REQ-018 The FSM state SHALL be {dir[1:0], phase}, where phase is one of Rest1, M1, Rest2, M2 (encoded 0..3).
REQ-019 On vs_tick with Character_Moving = 0: phase SHALL become Rest1, dir SHALL be held, and the step counter SHALL clear.
REQ-020 On vs_tick with Character_Moving = 1 and Direction != dir: dir SHALL take Direction, phase SHALL become Rest1, and the step counter SHALL clear.
REQ-021 On vs_tick with Character_Moving = 1 and Direction == dir:
- If the step counter equals STEP_DIV-1, the counter SHALL wrap to 0 and phase SHALL advance Rest1 -> M1 -> Rest2 -> M2 -> Rest1.
- Otherwise the counter SHALL increment.
REQ-022 The FSM SHALL not change state on any cycle without vs_tick.
REQ-023 The hit condition SHALL be SPRITE_X <= DrawX < SPRITE_X+SPRITE_W and SPRITE_Y <= DrawY < SPRITE_Y+SPRITE_H; the upper bounds are exclusive.
REQ-024 Rom_Addr SHALL be the address formed at cycle 0 and registered at cycle 1: rom_frame*SPRITE_W*SPRITE_H + (DrawY-SPRITE_Y)*SPRITE_W + col, where col = DrawX-SPRITE_X.
REQ-025 When there is no hit, Rom_Addr SHALL be 0.
REQ-026 The hit flag and the background colour SHALL be pipelined alongside Rom_Addr.
REQ-027 Red, Green and Blue SHALL appear 3 cycles after the DrawX/DrawY they correspond to.
REQ-028 For pixel colour, when hit = 1 and Rom_Data != TRANSPARENT_IDX, the output SHALL be the PALETTE[Rom_Data] entry.
REQ-029 In all other cases the output SHALL be the background: Red = 0, Green = 0, Blue = 8'h7F - DrawX[9:3].
REQ-030 Out-of-range palette indices SHALL render 24'h000000.

Reset
REQ-031 Reset SHALL asynchronously set the following to zero: dir = up, phase = Rest1, step counter, previous-VS sample, hit pipeline, Rom_Addr, Anim_Frame, Red, Green, Blue.
REQ-032 Reset asserted mid-walk SHALL abandon the phase immediately.
REQ-033 The first vs_tick after reset release SHALL be evaluated per REQ-019 through REQ-021.

Configuration
REQ-034 With macro SPRITE_MIRROR_EN defined:
- A right-facing dir SHALL read the left-facing ROM frames (rom_frame = 12 + phase).
- It SHALL use col = SPRITE_W-1-(DrawX-SPRITE_X), i.e. a horizontal flip.
- ROM frames 4-7 SHALL never be addressed.
REQ-035 Without SPRITE_MIRROR_EN, rom_frame SHALL equal Anim_Frame for all directions and col SHALL be unflipped.
REQ-036 Anim_Frame SHALL be unaffected by SPRITE_MIRROR_EN.

Structure
REQ-037 Package sprite_pkg SHALL hold the following, so that other sprite blocks share them:
- The dir_t and phase_t enums.
- PAL_W = 5.
- ROM_AW = 13.
- The 23-entry PALETTE constant array, including entries 6 = 24'h0058F8, 7 = 24'hFCFCFC, 20 = 24'h65B0FF, 21 = 24'h155ED8, 22 = 24'h24188A.
REQ-038 The walk FSM plus step counter SHALL be a sub-module, walk_fsm; the pixel pipeline SHALL remain in sprite_animator.

Verification
REQ-039 Scenario: STEP_DIV=2, Moving=1, Direction=0, 8 VS pulses -> Anim_Frame sequence 0,1,1,2,2,3,3,0 (one value per VS pulse).
REQ-040 Scenario: mid-walk at phase M1, Direction changed to 3 -> at the next VS, Anim_Frame = 12 and the step counter = 0.
REQ-041 Scenario: Moving dropped at phase Rest2 facing down -> at the next VS, Anim_Frame = 8, and it is held across further VS pulses.
REQ-042 Scenario: DrawX=292, DrawY=350 in frame 0 -> Rom_Addr = 0 at cycle 1; DrawX=308, DrawY=373 -> Rom_Addr = 407; DrawX=309 -> background RGB 3 cycles later, Blue = 8'h7F - 38 = 8'h59.
REQ-043 Scenario: Rom_Data = 0 inside the box -> background; Rom_Data = 7 -> RGB = FC/FC/FC.
REQ-044 Scenario: SPRITE_MIRROR_EN defined, facing right phase Rest1, DrawX=292, DrawY=350 -> Rom_Addr = 12*408 + 16 = 4912. Reset asserted asynchronously mid-line -> all outputs 0 before the next Clk edge.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: walk direction/phase types, ROM geometry and the shared
// 23-entry RGB888 palette used by all sprite blocks.
package sprite_pkg;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_RIGHT,
    DIR_DOWN,
    DIR_LEFT
  } dir_t;

  typedef enum logic [1:0] {
    PH_REST1,
    PH_M1,
    PH_REST2,
    PH_M2
  } phase_t;

  localparam int PAL_W  = 5;
  localparam int ROM_AW = 13;
  localparam int PAL_N  = 23;

  localparam logic [23:0] PALETTE [PAL_N] = '{
    24'h000000, 24'hF83800, 24'hF0D0B0, 24'h503000,
    24'hFFE0A8, 24'h0078F8, 24'h0058F8, 24'hFCFCFC,
    24'hBCBCBC, 24'hA40000, 24'hD82800, 24'hFC7460,
    24'hFCBCB0, 24'hF0BC3C, 24'hAEACAE, 24'h363301,
    24'h6C6C01, 24'hBBBD00, 24'h88D500, 24'h398802,
    24'h65B0FF, 24'h155ED8, 24'h24188A
  };

  // Codes past the table render black.
  function automatic logic [23:0] pal_lookup(
    input logic [PAL_W-1:0] idx
  );
    logic [23:0] c;
    c = 24'h000000;
    if (int'(idx) < PAL_N) c = PALETTE[idx];
    return c;
  endfunction

endpackage

// File: rtl/sprite_animator_if.sv
// sprite_animator_if: walk controls, pixel coordinates, sprite ROM
// port and colour outputs; slave is the animator, master the driver.
interface sprite_animator_if;
  import sprite_pkg::*;

  logic              VS;
  logic              Character_Moving;
  logic [1:0]        Direction;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [ROM_AW-1:0] Rom_Addr;
  logic [PAL_W-1:0]  Rom_Data;
  logic [3:0]        Anim_Frame;
  logic [7:0]        Red;
  logic [7:0]        Green;
  logic [7:0]        Blue;

  modport master (
    output VS, Character_Moving, Direction,
    output DrawX, DrawY, Rom_Data,
    input  Rom_Addr, Anim_Frame,
    input  Red, Green, Blue
  );

  modport slave (
    input  VS, Character_Moving, Direction,
    input  DrawX, DrawY, Rom_Data,
    output Rom_Addr, Anim_Frame,
    output Red, Green, Blue
  );

endinterface

// File: rtl/sprite_animator_walk_fsm.sv
// walk_fsm: direction/phase state plus the VS step divider; only
// moves on vs_tick.
module walk_fsm
  import sprite_pkg::*;
#(
  parameter int STEP_DIV = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs_tick,
  input  logic       Character_Moving,
  input  logic [1:0] Direction,
  output dir_t       dir,
  output phase_t     phase
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  dir_t          dir_n;
  phase_t        phase_n;
  logic [CW-1:0] cnt, cnt_n;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dir   <= DIR_UP;
      phase <= PH_REST1;
      cnt   <= '0;
    end else begin
      dir   <= dir_n;
      phase <= phase_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    dir_n   = dir;
    phase_n = phase;
    cnt_n   = cnt;
    if (vs_tick) begin
      if (!Character_Moving) begin
        phase_n = PH_REST1;
        cnt_n   = '0;
      end else if (Direction != dir) begin
        dir_n   = dir_t'(Direction);
        phase_n = PH_REST1;
        cnt_n   = '0;
      end else if (cnt == LAST) begin
        cnt_n   = '0;
        phase_n = phase_t'(phase + 2'd1);
      end else begin
        cnt_n   = cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_animator.sv
// sprite_animator: walk-cycle sprite renderer, 3-cycle pixel pipeline.
// Define SPRITE_MIRROR_EN to draw right-facing frames as flipped left.
module sprite_animator
  import sprite_pkg::*;
#(
  parameter int SPRITE_X        = 292,
  parameter int SPRITE_Y        = 350,
  parameter int SPRITE_W        = 17,
  parameter int SPRITE_H        = 24,
  parameter int STEP_DIV        = 8,
  parameter int TRANSPARENT_IDX = 0
) (
  input logic Clk,
  input logic Reset,
  sprite_animator_if.slave io
);

  dir_t   dir;
  phase_t phase;
  logic   vs_prev;
  logic   vs_tick;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) vs_prev <= 1'b0;
    else       vs_prev <= io.VS;
  end

  assign vs_tick = io.VS & ~vs_prev;

  walk_fsm #(
    .STEP_DIV (STEP_DIV)
  ) u_walk (
    .Clk              (Clk),
    .Reset            (Reset),
    .vs_tick          (vs_tick),
    .Character_Moving (io.Character_Moving),
    .Direction        (io.Direction),
    .dir              (dir),
    .phase            (phase)
  );

  assign io.Anim_Frame = {dir, phase};

  int                px, py, col;
  logic              hit;
  logic [3:0]        rom_frame;
  logic [ROM_AW-1:0] addr_d;
  logic [7:0]        bg_d;

  always_comb begin
    px  = int'(io.DrawX);
    py  = int'(io.DrawY);
    hit = (px >= SPRITE_X) && (px < SPRITE_X + SPRITE_W) &&
          (py >= SPRITE_Y) && (py < SPRITE_Y + SPRITE_H);
    rom_frame = {dir, phase};
    col       = px - SPRITE_X;
`ifdef SPRITE_MIRROR_EN
    if (dir == DIR_RIGHT) begin
      rom_frame = {DIR_LEFT, phase};
      col       = SPRITE_W - 1 - col;
    end
`endif
    addr_d = '0;
    if (hit)
      addr_d = ROM_AW'(int'(rom_frame) * SPRITE_W * SPRITE_H +
                       (py - SPRITE_Y) * SPRITE_W + col);
    bg_d = 8'h7F - {1'b0, io.DrawX[9:3]};
  end

  logic       hit1, hit2;
  logic [7:0] bg1, bg2;

  // Stage 2 lines hit/background up with the ROM read latency.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      io.Rom_Addr <= '0;
      hit1        <= 1'b0;
      bg1         <= '0;
      hit2        <= 1'b0;
      bg2         <= '0;
      io.Red      <= '0;
      io.Green    <= '0;
      io.Blue     <= '0;
    end else begin
      io.Rom_Addr <= addr_d;
      hit1        <= hit;
      bg1         <= bg_d;
      hit2        <= hit1;
      bg2         <= bg1;
      if (hit2 && io.Rom_Data != PAL_W'(TRANSPARENT_IDX))
        {io.Red, io.Green, io.Blue} <= pal_lookup(io.Rom_Data);
      else
        {io.Red, io.Green, io.Blue} <= {16'h0000, bg2};
    end
  end

endmodule

// File: tb/tb_sprite_animator.sv
// tb_sprite_animator: table vectors plus randomized walk/pixel traffic
// against a spec-level model; synchronous ROM model behind the bus.
module tb_sprite_animator;

  localparam int SX = 292;
  localparam int SY = 350;
  localparam int SW = 17;
  localparam int SH = 24;
  localparam int SD = 2;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  int m_dir = 0;
  int m_ph  = 0;
  int m_cnt = 0;

  logic [4:0] rom [8192];

  sprite_animator_if bus();

  sprite_animator #(
    .SPRITE_X        (SX),
    .SPRITE_Y        (SY),
    .SPRITE_W        (SW),
    .SPRITE_H        (SH),
    .STEP_DIV        (SD),
    .TRANSPARENT_IDX (0)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .io    (bus)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) bus.Rom_Data <= rom[bus.Rom_Addr];

  typedef struct {
    bit mov;
    int d;
    int frame;
  } walk_t;

  typedef struct {
    int          x;
    int          y;
    int          addr;
    int          rom_d;
    logic [23:0] rgb;
  } pix_t;

  walk_t wt[23];
  pix_t  pt[12];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] ref_pal(input int d);
    case (d)
      6:       return 24'h0058F8;
      7:       return 24'hFCFCFC;
      20:      return 24'h65B0FF;
      21:      return 24'h155ED8;
      22:      return 24'h24188A;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic bit ref_hit(input int x, input int y);
    return x >= SX && x < SX + SW && y >= SY && y < SY + SH;
  endfunction

  function automatic int ref_addr(input int x, input int y);
    int fr, col;
    if (!ref_hit(x, y)) return 0;
    fr  = m_dir * 4 + m_ph;
    col = x - SX;
`ifdef SPRITE_MIRROR_EN
    if (m_dir == 1) begin
      fr  = 12 + m_ph;
      col = SW - 1 - col;
    end
`endif
    return fr * SW * SH + (y - SY) * SW + col;
  endfunction

  function automatic logic [23:0] ref_rgb(input int x, input int y);
    int d;
    if (ref_hit(x, y)) begin
      d = int'(rom[ref_addr(x, y)]);
      if (d != 0) return ref_pal(d);
    end
    return {16'h0000, 8'(127 - x / 8)};
  endfunction

  task automatic pix(input string nm, input int x, input int y,
                     input int ea, input logic [23:0] ergb);
    @(negedge Clk);
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    @(posedge Clk);
    #1 chk({nm, " addr"}, 32'(bus.Rom_Addr), 32'(ea));
    @(posedge Clk);
    @(posedge Clk);
    #1 chk({nm, " rgb"}, {8'h00, bus.Red, bus.Green, bus.Blue},
           {8'h00, ergb});
  endtask

  task automatic pulse(input bit mov, input int d);
    @(negedge Clk);
    bus.VS               = 1'b1;
    bus.Character_Moving = mov;
    bus.Direction        = 2'(d);
    repeat (3) @(negedge Clk);
    bus.VS = 1'b0;
    @(negedge Clk);
    if (!mov) begin
      m_ph  = 0;
      m_cnt = 0;
    end else if (d != m_dir) begin
      m_dir = d;
      m_ph  = 0;
      m_cnt = 0;
    end else if (m_cnt == SD - 1) begin
      m_cnt = 0;
      m_ph  = (m_ph + 1) % 4;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " addr"}, 32'(bus.Rom_Addr), 32'd0);
    chk({nm, " frame"}, 32'(bus.Anim_Frame), 32'd0);
    chk({nm, " red"}, 32'(bus.Red), 32'd0);
    chk({nm, " green"}, 32'(bus.Green), 32'd0);
    chk({nm, " blue"}, 32'(bus.Blue), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int x, y, k, d;
    bit mv;

    bus.VS               = 1'b0;
    bus.Character_Moving = 1'b0;
    bus.Direction        = 2'd0;
    bus.DrawX            = '0;
    bus.DrawY            = '0;
    for (int i = 0; i < 8192; i++) begin
      k = int'($urandom_range(9));
      case (k)
        0:       rom[i] = 5'd0;
        1:       rom[i] = 5'd6;
        2:       rom[i] = 5'd7;
        3:       rom[i] = 5'd20;
        4:       rom[i] = 5'd21;
        5:       rom[i] = 5'd22;
        default: rom[i] = 5'(23 + $urandom_range(8));
      endcase
    end

    wt = '{
      '{1, 0, 0},  '{1, 0, 1},  '{1, 0, 1},  '{1, 0, 2},
      '{1, 0, 2},  '{1, 0, 3},  '{1, 0, 3},  '{1, 0, 0},
      '{1, 0, 0},  '{1, 0, 1},  '{1, 3, 12}, '{1, 3, 12},
      '{1, 3, 13}, '{1, 2, 8},  '{1, 2, 8},  '{1, 2, 9},
      '{1, 2, 9},  '{1, 2, 10}, '{0, 2, 8},  '{0, 2, 8},
      '{0, 1, 8},  '{1, 2, 8},  '{1, 2, 9}
    };

    pt = '{
      '{292, 350, 0,   7,  24'hFCFCFC},
      '{308, 373, 407, 6,  24'h0058F8},
      '{309, 373, 0,   -1, 24'h000059},
      '{293, 350, 1,   0,  24'h00005B},
      '{291, 350, 0,   -1, 24'h00005B},
      '{292, 349, 0,   -1, 24'h00005B},
      '{292, 374, 0,   -1, 24'h00005B},
      '{292, 373, 391, 20, 24'h65B0FF},
      '{300, 360, 178, 25, 24'h000000},
      '{0,   0,   0,   -1, 24'h00007F},
      '{1023, 360, 0,  -1, 24'h000000},
      '{308, 350, 16,  21, 24'h155ED8}
    };

    repeat (3) @(negedge Clk);
    chk_zero("reset");
    Reset = 1'b0;

    foreach (pt[i]) begin
      if (pt[i].rom_d >= 0) rom[pt[i].addr] = 5'(pt[i].rom_d);
    end
    foreach (pt[i])
      pix($sformatf("pix%0d", i), pt[i].x, pt[i].y,
          pt[i].addr, pt[i].rgb);

    foreach (wt[i]) begin
      pulse(wt[i].mov, wt[i].d);
      chk($sformatf("walk%0d", i), 32'(bus.Anim_Frame),
          32'(wt[i].frame));
    end

    pulse(1'b1, 1);
    chk("right frame", 32'(bus.Anim_Frame), 32'd4);
`ifdef SPRITE_MIRROR_EN
    rom[4912] = 5'd22;
    rom[4896] = 5'd0;
    pix("right 292", 292, 350, 4912, 24'h24188A);
    pix("right 308", 308, 350, 4896, 24'h000059);
`else
    rom[1632] = 5'd22;
    rom[1648] = 5'd0;
    pix("right 292", 292, 350, 1632, 24'h24188A);
    pix("right 308", 308, 350, 1648, 24'h000059);
`endif

    for (int i = 0; i < 60; i++) begin
      mv = ($urandom_range(3) != 0);
      if ($urandom_range(4) == 0) d = int'($urandom_range(3));
      else                        d = m_dir;
      pulse(mv, d);
      chk("rnd frame", 32'(bus.Anim_Frame), 32'(m_dir * 4 + m_ph));
      x = int'($urandom_range(320, 280));
      y = int'($urandom_range(380, 344));
      pix("rnd pix", x, y, ref_addr(x, y), ref_rgb(x, y));
    end

    pulse(1'b1, 2);
    chk("pre-reset frame", 32'(bus.Anim_Frame), 32'(m_dir * 4 + m_ph));
    @(negedge Clk);
    bus.DrawX = 10'd300;
    bus.DrawY = 10'd360;
    repeat (4) @(posedge Clk);
    #3 Reset = 1'b1;
    #1 chk_zero("async reset");
    m_dir = 0;
    m_ph  = 0;
    m_cnt = 0;
    @(negedge Clk);
    Reset = 1'b0;
    pulse(1'b1, 0);
    chk("post-reset tick1", 32'(bus.Anim_Frame), 32'd0);
    pulse(1'b1, 0);
    chk("post-reset tick2", 32'(bus.Anim_Frame), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
